// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Shifts run one bit per cycle. Results and flags are registered and held
// until the consumer accepts them.
// Optional feature: define ALU_SEQ_MUL_EN to enable the iterative shift-add
// multiplier on opcode 111. Without it, 111 returns zero in a single cycle.
module alu_seq #(
  parameter int unsigned W   = 8,
  parameter int unsigned OPW = 3,
  localparam int unsigned SHW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  input  logic [OPW-1:0] op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic           zero,
  output logic           sign,
  output logic           carry,
  output logic           is_equal
);

  localparam logic [OPW-1:0] OpAdd = OPW'(3'd0);
  localparam logic [OPW-1:0] OpSub = OPW'(3'd1);
  localparam logic [OPW-1:0] OpShr = OPW'(3'd2);
  localparam logic [OPW-1:0] OpShl = OPW'(3'd3);
  localparam logic [OPW-1:0] OpPar = OPW'(3'd4);
  localparam logic [OPW-1:0] OpAnd = OPW'(3'd5);
  localparam logic [OPW-1:0] OpXor = OPW'(3'd6);
`ifdef ALU_SEQ_MUL_EN
  localparam logic [OPW-1:0] OpMul = OPW'(3'd7);
`endif
  localparam logic [W:0]     WVal  = (W + 1)'(W);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   work_q, work_d;     // shift operand, or multiplier bits
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [OPW-1:0] op_q, op_d;
  logic [W-1:0]   result_q, result_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           sign_q, sign_d;
  logic           eq_q, eq_d;
  logic           finish;
  logic [W-1:0]   fin_val;
`ifdef ALU_SEQ_MUL_EN
  logic [2*W-1:0] prod_q, prod_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] prod_sum;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign sign      = sign_q;
  assign is_equal  = eq_q;

  // Next-state, datapath and flag computation.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    eq_d     = eq_q;
    finish   = 1'b0;
    fin_val  = '0;
`ifdef ALU_SEQ_MUL_EN
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    prod_sum = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = op;
          eq_d    = (a == c);
          zero_d  = 1'b0;
          sign_d  = 1'b0;
          carry_d = 1'b0;
          work_d  = a;
          case (op)
            OpShr, OpShl: begin
              cnt_d = ({1'b0, b} >= WVal) ? SHW'(W) : SHW'(b);
              if (cnt_d == '0) begin
                finish  = 1'b1;
                fin_val = a;
              end else begin
                state_d = StBusy;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OpMul: begin
              prod_d  = '0;
              mcand_d = {{W{1'b0}}, a};
              work_d  = b;
              cnt_d   = SHW'(W);
              state_d = StBusy;
            end
`endif
            default: begin
              finish = 1'b1;
              case (op)
                OpAdd: {carry_d, fin_val} = {1'b0, a} + {1'b0, b};
                OpSub: {carry_d, fin_val} = {1'b0, a} - {1'b0, b};
                OpPar: begin
                  fin_val = a;
                  fin_val[b[SHW-2:0]] = ^a;
                end
                OpAnd: fin_val = a & b;
                OpXor: fin_val = a ^ b;
                default: fin_val = '0;
              endcase
            end
          endcase
        end
      end
      StBusy: begin
        cnt_d = cnt_q - SHW'(1);
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OpMul) begin
          prod_sum = prod_q + (work_q[0] ? mcand_q : '0);
          prod_d   = prod_sum;
          mcand_d  = mcand_q << 1;
          work_d   = work_q >> 1;
          if (cnt_q == SHW'(1)) begin
            finish  = 1'b1;
            fin_val = prod_sum[W-1:0];
            carry_d = |prod_sum[2*W-1:W];
          end
        end else
`endif
        begin
          if (op_q == OpShr) begin
            carry_d = work_q[0];
            work_d  = work_q >> 1;
          end else begin
            carry_d = work_q[W-1];
            work_d  = work_q << 1;
          end
          if (cnt_q == SHW'(1)) begin
            finish  = 1'b1;
            fin_val = work_d;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Result and zero/sign only change when an operation completes.
    if (finish) begin
      state_d  = StDone;
      result_d = fin_val;
      zero_d   = (fin_val == '0);
      sign_d   = fin_val[W-1];
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      eq_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_q   <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      eq_q     <= eq_d;
`ifdef ALU_SEQ_MUL_EN
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
`endif
    end
  end

endmodule
